// File: rtl/lut_ram_arb_pkg.sv
// Shared types for the lut_ram arbiter: sweep FSM states and requester ids.
package lut_ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the winner of the next contested cycle.
module rr_arb2
  import lut_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t ptr;
  logic    contested;

  assign contested = &req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt = req;
    if (contested) gnt = (ptr == 1'b0) ? 2'b01 : 2'b10;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr <= 1'b0;
    else if (contested) ptr <= ~ptr;
  end

endmodule

// File: rtl/lut_ram_arbiter.sv
// Shares one lut_ram between two requesters; zero-fills the RAM after reset or clear.
module lut_ram_arbiter
  import lut_ram_arb_pkg::*;
#(
  parameter  int LUT_WIDTH = 32,
  parameter  int LUT_DEPTH = 256,
  localparam int AW        = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 init_done,
  input  logic                 req0_valid,
  input  logic                 req0_wr,
  input  logic [AW-1:0]        req0_addr,
  input  logic [LUT_WIDTH-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 rsp0_valid,
  output logic [LUT_WIDTH-1:0] rsp0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_wr,
  input  logic [AW-1:0]        req1_addr,
  input  logic [LUT_WIDTH-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 rsp1_valid,
  output logic [LUT_WIDTH-1:0] rsp1_rdata,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        mem_wr_addr,
  output logic [AW-1:0]        mem_rd_addr,
  output logic [LUT_WIDTH-1:0] mem_wr_data,
  input  logic [LUT_WIDTH-1:0] mem_rd_data
);

  state_t               state, state_nxt;
  logic [AW-1:0]        cnt, cnt_nxt;
  logic                 arb_en;
  logic [1:0]           wr_req, rd_req, wr_gnt, rd_gnt;
  logic [AW-1:0]        wr_addr_sel, rd_addr_sel;
  logic [LUT_WIDTH-1:0] wr_data_sel;
  logic                 rd_oor;

  // Only matters for non-power-of-2 depths; otherwise always true.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(LUT_DEPTH);
  endfunction

  assign arb_en = (state == RUN) && !clear;
  assign wr_req = {req1_valid &  req1_wr, req0_valid &  req0_wr} & {2{arb_en}};
  assign rd_req = {req1_valid & ~req1_wr, req0_valid & ~req0_wr} & {2{arb_en}};

  rr_arb2 u_wr_arb (.clk(clk), .rst_n(rst_n), .req(wr_req), .gnt(wr_gnt));
  rr_arb2 u_rd_arb (.clk(clk), .rst_n(rst_n), .req(rd_req), .gnt(rd_gnt));

  assign wr_addr_sel = wr_gnt[1] ? req1_addr  : req0_addr;
  assign wr_data_sel = wr_gnt[1] ? req1_wdata : req0_wdata;
  assign rd_addr_sel = rd_gnt[1] ? req1_addr  : req0_addr;
  assign rd_oor      = !in_range(rd_addr_sel);

  assign req0_ready = wr_gnt[0] | rd_gnt[0];
  assign req1_ready = wr_gnt[1] | rd_gnt[1];
  assign init_done  = (state == RUN);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    unique case (state)
      INIT: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = cnt;
        cnt_nxt     = cnt + 1'b1;
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == AW'(LUT_DEPTH - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
        if ((|wr_gnt) && in_range(wr_addr_sel)) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = wr_addr_sel;
          mem_wr_data = wr_data_sel;
        end
        if (|rd_gnt) mem_rd_addr = rd_addr_sel;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Read data is captured on the accept edge, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd_gnt[0];
      rsp1_valid <= rd_gnt[1];
      if (rd_gnt[0]) rsp0_rdata <= rd_oor ? '0 : mem_rd_data;
      if (rd_gnt[1]) rsp1_rdata <= rd_oor ? '0 : mem_rd_data;
    end
  end

endmodule
